// File: rtl/ifu_fetch.sv
// Instruction fetch FSM: request at PC, wait for memory, hold for IDU (>=3 cycles/instr); optional IFU_MISALIGN_CHK_EN.
// Request held until i_mem_req_ready; instruction held until i_idu_ready; redirect taken only at retirement.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
module ifu_fetch #(
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RST_PC = ADDR_WIDTH'(32'h8000_0000)
) (
    input  logic                  i_sys_clk,
    input  logic                  i_sys_rst_n,
    input  logic                  i_exu_jmp_en,
    input  logic [ADDR_WIDTH-1:0] i_exu_jmp_pc,
    output logic                  o_mem_req_valid,
    input  logic                  i_mem_req_ready,
    output logic [ADDR_WIDTH-1:0] o_mem_req_addr,
    input  logic                  i_mem_rsp_valid,
    input  logic [INST_WIDTH-1:0] i_mem_rsp_data,
    output logic                  o_ifu_valid,
    input  logic                  i_idu_ready,
    output logic [ADDR_WIDTH-1:0] o_ifu_pc,
`ifdef IFU_MISALIGN_CHK_EN
    output logic [INST_WIDTH-1:0] o_ifu_inst,
    output logic                  o_ifu_misalign
`else
    output logic [INST_WIDTH-1:0] o_ifu_inst
`endif
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
`ifdef IFU_MISALIGN_CHK_EN
        S_HOLD = 2'd2,
        S_TRAP = 2'd3
`else
        S_HOLD = 2'd2
`endif
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] w_pc_nxt;
    logic [INST_WIDTH-1:0] r_inst;
    logic [INST_WIDTH-1:0] w_inst_nxt;

`ifdef IFU_MISALIGN_CHK_EN
    assign o_ifu_misalign = i_sys_rst_n && (r_state == S_TRAP);
`else
    // Low target bits are discarded: fetches are always word aligned.
    logic w_unused_jmp_lsb;
    assign w_unused_jmp_lsb = ^i_exu_jmp_pc[1:0];
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_inst_nxt      = r_inst;
        o_mem_req_valid = 1'b0;
        o_mem_req_addr  = '0;
        o_ifu_valid     = 1'b0;
        o_ifu_pc        = '0;
        o_ifu_inst      = '0;

        case (r_state)
            S_REQ: begin
                if (i_mem_req_ready) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (i_mem_rsp_valid) begin
                    w_inst_nxt  = i_mem_rsp_data;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (i_idu_ready) begin
                    w_state_nxt = S_REQ;
                    if (!i_exu_jmp_en) w_pc_nxt = r_pc + ADDR_WIDTH'(4);
`ifdef IFU_MISALIGN_CHK_EN
                    else if (i_exu_jmp_pc[1:0] != 2'b00) w_state_nxt = S_TRAP;
`endif
                    else w_pc_nxt = {i_exu_jmp_pc[ADDR_WIDTH-1:2], 2'b00};
                end
            end
            default: ;
        endcase

        // Outputs are forced low while reset is held, regardless of state.
        if (i_sys_rst_n) begin
            if (r_state == S_REQ) begin
                o_mem_req_valid = 1'b1;
                o_mem_req_addr  = r_pc;
            end
            if (r_state == S_HOLD) begin
                o_ifu_valid = 1'b1;
                o_ifu_pc    = r_pc;
                o_ifu_inst  = r_inst;
            end
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (!i_sys_rst_n) begin
            r_state <= S_REQ;
            r_pc    <= RST_PC;
            r_inst  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_inst  <= w_inst_nxt;
        end
    end

endmodule
